pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Control FSM that drives the program counter's en_PC / load_en / load inputs.
//  Accepts one decoded flow-control op at a time: SEQ, JMP, BRANCH, CALL, RET, HALT.
//  Holds an internal return-address stack for CALL/RET.
//  Sits between the instruction decoder and the program counter.
// PARAMETERS
//  AW     8  address width; matches the PC width
//  DEPTH  4  return-stack entries, >=1
//  OFFW   8  signed branch offset width, <=AW
// PORTS
//  clk        in   1     clock, rising edge
//  reset      in   1     asynchronous, active-high reset
//  op_valid   in   1     decoder presents an op
//  op_ready   out  1     sequencer can accept; transfer = op_valid & op_ready
//  op_type    in   3     0 SEQ, 1 JMP, 2 BRANCH, 3 CALL, 4 RET, 5 HALT, 6-7 treated as SEQ
//  target     in   AW    absolute target for JMP/CALL
//  offset     in   OFFW  signed offset for BRANCH
//  cond       in   1     BRANCH taken when 1
//  pc_in      in   AW    current PC value
//  stall      in   1     freeze sequencing
//  en_PC      out  1     increment strobe to PC
//  load_en    out  1     load strobe to PC
//  load       out  AW    value to load into PC
//  halted     out  1     HALT executed (sticky)
//  fault      out  1     stack error (sticky)
//  fault_code out  2     01 overflow, 10 underflow, 00 none
// BEHAVIOUR
//  Reset (async, immediate): state=RUN; en_PC=0, load_en=0, load=0, sp=0,
//   halted=0, fault=0, fault_code=0. op_ready=1 once reset deasserts.
//  States: RUN, ISSUE, PUSH, POP, HALTED, FAULT.
//  op_ready = (state==RUN) & ~stall. Accept in cycle N captures op_type, target,
//   offset, cond and pc_in.
//  en_PC and load_en are high only in ISSUE with stall=0; never both high.
//  SEQ: N+1 ISSUE, en_PC=1. Back to RUN in N+2.
//  Branch not taken: same as SEQ.
//  JMP: N+1 ISSUE, load_en=1, load=target.
//  BRANCH taken: N+1 ISSUE, load_en=1, load=(pc_in + sign_ext(offset)) mod 2^AW.
//  CALL, stack not full:
//   - N+1 PUSH: stack[sp] <= (pc_in+1) mod 2^AW, sp <= sp+1.
//   - N+2 ISSUE: load_en=1, load=target.
//  CALL, stack full (sp==DEPTH): no push, no PC strobe; N+1 FAULT, fault=1, fault_code=01.
//  RET, stack not empty:
//   - N+1 POP: load <= stack[sp-1], sp <= sp-1.
//   - N+2 ISSUE: load_en=1.
//  RET, stack empty (sp==0): N+1 FAULT, fault_code=10, no strobe.
//  HALT: N+1 HALTED. No strobes; halted=1; op_ready=0 until reset.
//  FAULT: no strobes; op_ready=0 until reset.
//  load register: updated only on JMP/BRANCH/CALL/RET paths; otherwise holds its value.
//  stall=1: state, sp and stack frozen; en_PC and load_en forced 0; op_ready=0.
//   Remaining steps resume on the first cycle with stall=0. Each strobe lasts exactly
//   one unstalled cycle.
//  sp range 0..DEPTH. Its width is clog2(DEPTH+1). Stack contents are not cleared by
//   reset.
//  Reset during PUSH/POP/ISSUE aborts the op: no strobe is emitted and sp returns to 0.
//  Throughput: one op per 2 cycles (SEQ/JMP/BRANCH), one op per 3 cycles (CALL/RET).
// TESTING
//  Reset release, SEQ with pc_in=0x10 -> en_PC=1 for exactly 1 cycle at N+1,
//   load_en=0, op_ready=0 in N+1.
//  BRANCH with pc_in=0x05, offset=0xFA (-6), cond=1 -> load=0xFF, load_en=1 at N+1;
//   same op with cond=0 -> en_PC=1.
//  CALL target=0x40, pc_in=0xFF -> stack gets 0x00, load_en at N+2 with load=0x40;
//   then RET -> load=0x00 at N+2.
//  DEPTH=4: five nested CALLs -> fifth gives fault=1, fault_code=01, no strobe,
//   op_ready stays 0; RET on empty stack after reset -> fault_code=10.
//  JMP accepted, stall=1 for 3 cycles during ISSUE -> no strobe while stalled;
//   load_en=1 for 1 cycle after stall drops.
//  HALT -> halted=1, op_ready=0 for 20 cycles; async reset mid-CALL (PUSH state)
//   -> all outputs 0 immediately, sp=0, no load_en.

Source files
------------

// File: rtl/pc_sequencer.sv
// Flow-control sequencer: turns decoded SEQ/JMP/BRANCH/CALL/RET/HALT ops into
// program-counter increment/load strobes, with an internal return-address stack.
module pc_sequencer #(
  parameter int unsigned AW    = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned OFFW  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [2:0]      op_type,
  input  logic [AW-1:0]   target,
  input  logic [OFFW-1:0] offset,
  input  logic            cond,
  input  logic [AW-1:0]   pc_in,
  input  logic            stall,
  output logic            en_PC,
  output logic            load_en,
  output logic [AW-1:0]   load,
  output logic            halted,
  output logic            fault,
  output logic [1:0]      fault_code
);

  localparam int unsigned SPW = $clog2(DEPTH + 1);
  localparam int unsigned IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] OP_JMP    = 3'd1;
  localparam logic [2:0] OP_BRANCH = 3'd2;
  localparam logic [2:0] OP_CALL   = 3'd3;
  localparam logic [2:0] OP_RET    = 3'd4;
  localparam logic [2:0] OP_HALT   = 3'd5;

  localparam logic [1:0] FC_OVF = 2'b01;
  localparam logic [1:0] FC_UNF = 2'b10;

  typedef enum logic [2:0] {
    S_RUN    = 3'd0,
    S_ISSUE  = 3'd1,
    S_PUSH   = 3'd2,
    S_POP    = 3'd3,
    S_HALTED = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [SPW-1:0]  r_sp, w_sp_nxt;
  logic [AW-1:0]   r_load, w_load_nxt;
  logic [AW-1:0]   r_ret_addr, w_ret_addr_nxt;
  logic            r_inc, w_inc_nxt;          // ISSUE pulses en_PC (1) or load_en (0)
  logic            r_halted, w_halted_nxt;
  logic            r_fault, w_fault_nxt;
  logic [1:0]      r_fault_code, w_fault_code_nxt;
  logic            w_push;
  logic            w_accept;
  logic            w_full;
  logic            w_empty;
  logic [AW-1:0]   w_off_ext;
  logic [AW-1:0]   w_top;
  logic [AW-1:0]   r_stack [DEPTH];

  assign w_full    = (r_sp == SPW'(DEPTH));
  assign w_empty   = (r_sp == '0);
  assign w_off_ext = AW'($signed(offset));
  assign w_top     = r_stack[IW'(r_sp - SPW'(1))];

  assign load       = r_load;
  assign halted     = r_halted;
  assign fault      = r_fault;
  assign fault_code = r_fault_code;

  // Next-state and strobe decode
  always_comb begin
    w_state_nxt      = r_state;
    w_sp_nxt         = r_sp;
    w_load_nxt       = r_load;
    w_ret_addr_nxt   = r_ret_addr;
    w_inc_nxt        = r_inc;
    w_halted_nxt     = r_halted;
    w_fault_nxt      = r_fault;
    w_fault_code_nxt = r_fault_code;
    w_push           = 1'b0;
    w_accept         = 1'b0;
    op_ready         = 1'b0;
    en_PC            = 1'b0;
    load_en          = 1'b0;

    case (r_state)
      S_RUN: begin
        op_ready = ~stall & ~reset;
        w_accept = op_valid & ~stall & ~reset;
        if (w_accept) begin
          case (op_type)
            OP_JMP: begin
              w_inc_nxt   = 1'b0;
              w_load_nxt  = target;
              w_state_nxt = S_ISSUE;
            end
            OP_BRANCH: begin
              w_inc_nxt   = ~cond;
              if (cond) w_load_nxt = pc_in + w_off_ext;
              w_state_nxt = S_ISSUE;
            end
            OP_CALL: begin
              if (w_full) begin
                w_fault_nxt      = 1'b1;
                w_fault_code_nxt = FC_OVF;
                w_state_nxt      = S_FAULT;
              end else begin
                w_inc_nxt      = 1'b0;
                w_load_nxt     = target;
                w_ret_addr_nxt = pc_in + AW'(1);
                w_state_nxt    = S_PUSH;
              end
            end
            OP_RET: begin
              if (w_empty) begin
                w_fault_nxt      = 1'b1;
                w_fault_code_nxt = FC_UNF;
                w_state_nxt      = S_FAULT;
              end else begin
                w_inc_nxt   = 1'b0;
                w_state_nxt = S_POP;
              end
            end
            OP_HALT: begin
              w_halted_nxt = 1'b1;
              w_state_nxt  = S_HALTED;
            end
            default: begin
              w_inc_nxt   = 1'b1;
              w_state_nxt = S_ISSUE;
            end
          endcase
        end
      end
      S_PUSH: begin
        if (!stall) begin
          w_push      = 1'b1;
          w_sp_nxt    = r_sp + SPW'(1);
          w_state_nxt = S_ISSUE;
        end
      end
      S_POP: begin
        if (!stall) begin
          w_load_nxt  = w_top;
          w_sp_nxt    = r_sp - SPW'(1);
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!stall) begin
          en_PC       = r_inc;
          load_en     = ~r_inc;
          w_state_nxt = S_RUN;
        end
      end
      S_HALTED: w_state_nxt = S_HALTED;
      S_FAULT:  w_state_nxt = S_FAULT;
      default:  w_state_nxt = S_RUN;
    endcase
  end

  // State and control registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_RUN;
      r_sp         <= '0;
      r_load       <= '0;
      r_ret_addr   <= '0;
      r_inc        <= 1'b0;
      r_halted     <= 1'b0;
      r_fault      <= 1'b0;
      r_fault_code <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_sp         <= w_sp_nxt;
      r_load       <= w_load_nxt;
      r_ret_addr   <= w_ret_addr_nxt;
      r_inc        <= w_inc_nxt;
      r_halted     <= w_halted_nxt;
      r_fault      <= w_fault_nxt;
      r_fault_code <= w_fault_code_nxt;
    end
  end

  // Return-address storage; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (w_push) r_stack[IW'(r_sp)] <= r_ret_addr;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus queues expected PC strobes,
// a negedge monitor pops and compares them against en_PC/load_en/load.
module tb_pc_sequencer;

  localparam logic [2:0] SEQ = 3'd0, JMP = 3'd1, BR = 3'd2, CALL = 3'd3, RET = 3'd4, HALT = 3'd5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       op_valid = 1'b0;
  logic       op_ready;
  logic [2:0] op_type = '0;
  logic [7:0] target = '0;
  logic [7:0] offset = '0;
  logic       cond = 1'b0;
  logic [7:0] pc_in = '0;
  logic       stall = 1'b0;
  logic       en_PC, load_en;
  logic [7:0] load;
  logic       halted, fault;
  logic [1:0] fault_code;

  typedef struct {
    bit         inc;
    logic [7:0] ld;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  pc_sequencer #(.AW(8), .DEPTH(4), .OFFW(8)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op_type(op_type), .target(target), .offset(offset), .cond(cond),
    .pc_in(pc_in), .stall(stall), .en_PC(en_PC), .load_en(load_en),
    .load(load), .halted(halted), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe must match the head of the scoreboard, on the expected cycle
  always @(negedge clk) begin
    if (!reset && (en_PC || load_en)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected cyc=%0d en_PC=%b load_en=%b load=%h", cyc, en_PC, load_en, load);
      end else begin
        mon_e = sb.pop_front();
        if (en_PC !== mon_e.inc || load_en !== !mon_e.inc ||
            (!mon_e.inc && load !== mon_e.ld) || cyc != mon_e.cyc) begin
          errors++;
          $display("FAIL strobe cyc=%0d en_PC=%b load_en=%b load=%h required cyc=%0d en_PC=%b load_en=%b load=%h",
                   cyc, en_PC, load_en, load, mon_e.cyc, mon_e.inc, !mon_e.inc, mon_e.ld);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    op_valid = 1'b0;
    stall = 1'b0;
    idle(2);
    reset = 1'b0;
  endtask

  // Present one op for one cycle; optionally queue the strobe expected 'lat' cycles later
  task automatic do_op(input logic [2:0] t, input logic [7:0] tgt, input logic [7:0] off,
                       input logic c, input logic [7:0] pc, input bit exp_strobe,
                       input bit exp_inc, input logic [7:0] exp_load, input int lat,
                       input int post);
    @(negedge clk);
    chk("op_ready_before", int'(op_ready), 1);
    op_valid = 1'b1;
    op_type  = t;
    target   = tgt;
    offset   = off;
    cond     = c;
    pc_in    = pc;
    if (exp_strobe) sb.push_back('{exp_inc, exp_load, cyc + lat});
    @(negedge clk);
    op_valid = 1'b0;
    chk("op_ready_n1", int'(op_ready), 0);
    idle(post);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_en_PC", int'(en_PC), 0);
    chk("rst_load_en", int'(load_en), 0);
    chk("rst_load", int'(load), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_fault_code", int'(fault_code), 0);
    chk("rst_op_ready", int'(op_ready), 0);
    idle(2);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_op_ready", int'(op_ready), 1);

    // SEQ, BRANCH taken / not taken, JMP
    do_op(SEQ,  8'h00, 8'h00, 1'b0, 8'h10, 1, 1, 8'h00, 1, 1);
    do_op(BR,   8'h00, 8'hFA, 1'b1, 8'h05, 1, 0, 8'hFF, 1, 1);
    chk("branch_load", int'(load), 8'hFF);
    do_op(BR,   8'h00, 8'hFA, 1'b0, 8'h05, 1, 1, 8'h00, 1, 1);
    chk("load_held_after_seq", int'(load), 8'hFF);
    do_op(JMP,  8'h33, 8'h00, 1'b0, 8'h10, 1, 0, 8'h33, 1, 1);
    do_op(3'd7, 8'h00, 8'h00, 1'b0, 8'h11, 1, 1, 8'h00, 1, 1);

    // CALL wrapping return address, then RET
    do_op(CALL, 8'h40, 8'h00, 1'b0, 8'hFF, 1, 0, 8'h40, 2, 2);
    do_op(RET,  8'h00, 8'h00, 1'b0, 8'h40, 1, 0, 8'h00, 2, 2);

    // Two nested calls return in LIFO order
    do_op(CALL, 8'h80, 8'h00, 1'b0, 8'h20, 1, 0, 8'h80, 2, 2);
    do_op(CALL, 8'h90, 8'h00, 1'b0, 8'h30, 1, 0, 8'h90, 2, 2);
    do_op(RET,  8'h00, 8'h00, 1'b0, 8'h90, 1, 0, 8'h31, 2, 2);
    do_op(RET,  8'h00, 8'h00, 1'b0, 8'h80, 1, 0, 8'h21, 2, 2);

    // JMP with a 3-cycle stall during ISSUE
    @(negedge clk);
    op_valid = 1'b1; op_type = JMP; target = 8'h77; pc_in = 8'h00;
    sb.push_back('{1'b0, 8'h77, cyc + 4});
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    stall = 1'b1;
    @(negedge clk);
    chk("stall_op_ready", int'(op_ready), 0);
    chk("stall_load_en", int'(load_en), 0);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    stall = 1'b0;
    idle(2);
    chk("stall_ready_after", int'(op_ready), 1);

    // Stack overflow on the fifth nested CALL
    do_reset();
    for (int i = 0; i < 4; i++)
      do_op(CALL, 8'(8'h80 + i), 8'h00, 1'b0, 8'(8'h20 + i), 1, 0, 8'(8'h80 + i), 2, 2);
    do_op(CALL, 8'h84, 8'h00, 1'b0, 8'h24, 0, 0, 8'h00, 0, 0);
    chk("ovf_fault", int'(fault), 1);
    chk("ovf_code", int'(fault_code), 2'b01);
    chk("ovf_halted", int'(halted), 0);
    op_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("ovf_op_ready", int'(op_ready), 0);
    end
    op_valid = 1'b0;

    // Stack underflow: RET right after reset
    do_reset();
    do_op(RET, 8'h00, 8'h00, 1'b0, 8'h10, 0, 0, 8'h00, 0, 2);
    chk("unf_fault", int'(fault), 1);
    chk("unf_code", int'(fault_code), 2'b10);

    // HALT is sticky; ops presented afterwards are ignored
    do_reset();
    do_op(HALT, 8'h00, 8'h00, 1'b0, 8'h10, 0, 0, 8'h00, 0, 0);
    op_valid = 1'b1;
    op_type = SEQ;
    for (int i = 0; i < 20; i++) begin
      chk("halt_halted", int'(halted), 1);
      chk("halt_op_ready", int'(op_ready), 0);
      @(negedge clk);
    end
    op_valid = 1'b0;
    chk("halt_fault", int'(fault), 0);

    // Async reset while in PUSH aborts the CALL
    do_reset();
    do_op(JMP, 8'h55, 8'h00, 1'b0, 8'h00, 1, 0, 8'h55, 1, 2);
    do_op(CALL, 8'h60, 8'h00, 1'b0, 8'h12, 0, 0, 8'h00, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_load", int'(load), 0);
    chk("midrst_load_en", int'(load_en), 0);
    chk("midrst_en_PC", int'(en_PC), 0);
    chk("midrst_op_ready", int'(op_ready), 0);
    chk("midrst_halted", int'(halted), 0);
    chk("midrst_fault", int'(fault), 0);
    idle(2);
    reset = 1'b0;
    idle(4);
    do_op(RET, 8'h00, 8'h00, 1'b0, 8'h10, 0, 0, 8'h00, 0, 1);
    chk("midrst_sp_zero", int'(fault_code), 2'b10);

    idle(4);
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
